// File: rtl/ccd_dvp_capture_pkg.sv
// Shared definitions for the DVP capture path: FSM encoding, pixel packing
// geometry and the sideband bit positions inside a buffered stream word.
package ccd_dvp_capture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int PPW       = 4;                 // pixels per output word
  localparam int PIX_W     = 16;                // container width of one pixel
  localparam int WORD_W    = PIX_W * PPW;       // packed pixel payload
  localparam int LANE_W    = $clog2(PPW);       // lane index width
  localparam int TUSER_BIT = WORD_W;            // start-of-frame marker
  localparam int TLAST_BIT = WORD_W + 1;        // end-of-line marker
  localparam int BUF_W     = WORD_W + 2;        // payload plus both markers

endpackage

// File: rtl/ccd_cap_skidbuf.sv
// Two-entry valid/ready buffer. The head entry drives the output and stays
// stable until accepted. A push into a full buffer is accepted only when a pop
// happens in the same cycle; otherwise the word is dropped and flagged.
module ccd_cap_skidbuf #(
  parameter int W = 66
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         drop,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [1:0]   cnt_q;
  logic         pop;

  assign pop       = (cnt_q != 2'd0) && out_ready;
  assign drop      = in_valid && (cnt_q == 2'd2) && !pop;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;

  // Occupancy and entry update for every push/pop combination.
  // NOTE: state is written with <= so every register samples pre-edge values,
  // which is what makes head_q <= tail_q and tail_q <= in_data a clean shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the two entries are reset because head_q is the visible output
      // data and must read as zero after reset, not because the count needs it.
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      case (cnt_q)
        2'd0: begin
          if (in_valid) begin
            head_q <= in_data;
            cnt_q  <= 2'd1;
          end
        end
        2'd1: begin
          if (in_valid && pop) begin
            head_q <= in_data;
          end else if (in_valid) begin
            tail_q <= in_data;
            cnt_q  <= 2'd2;
          end else if (pop) begin
            cnt_q  <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head_q <= tail_q;
            if (in_valid) tail_q <= in_data;
            else          cnt_q  <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/ccd_dvp_capture.sv
// DVP window capture: registers the AFE pixel bus and syncs, tracks pixel and
// line position, crops the configured window, packs four 16-bit pixels per
// word and hands words with SOF/EOL markers to a two-entry output buffer.
module ccd_dvp_capture
  import ccd_dvp_capture_pkg::*;
#(
  parameter int DW   = 14,
  parameter int CNTW = 15,
  parameter int PPW  = ccd_dvp_capture_pkg::PPW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [CNTW-1:0]   h_start,
  input  logic [CNTW-1:0]   h_width,
  input  logic [CNTW-1:0]   v_start,
  input  logic [CNTW-1:0]   v_height,
  input  logic              dvp_vsync_n,
  input  logic              dvp_hsync_n,
  input  logic [DW-1:0]     dvp_data,
  output logic [16*PPW-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tuser,
  output logic              m_tlast,
  output logic              frame_done,
  output logic              overflow,
  output logic [15:0]       frame_cnt
);

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  localparam logic [CNTW-1:0] W_MASK  = ~CNTW'(PPW - 1);
  localparam int              ACC_W   = WORD_W - PIX_W;

  // Input stage and sync edge detection.
  logic          vs_r, vs_rr, hs_r, hs_rr;
  logic [DW-1:0] d_r;
  logic          vs_assert, vs_deassert, hs_assert, hs_deassert;

  // Latched window configuration.
  logic [CNTW-1:0] cfg_hs, cfg_w, cfg_vs, cfg_vh;

  // Position tracking.
  logic [CNTW-1:0] pix_q, cur_pix, line_idx, pix_off, line_off;
  logic            line_ok;

  // Qualification of the current pixel.
  logic in_h, in_v, cap, lane_end, px_tuser, px_tlast, last_px, end_ev;

  // Pipeline stages between qualification and word completion.
  logic              q_cap, q_word, q_user, q_last, q_end;
  logic [PIX_W-1:0]  q_data;
  logic [ACC_W-1:0]  acc;
  logic              w_v, w_user, w_last, w_end;
  logic [WORD_W-1:0] w_data;

  // Control.
  state_t            state_q, state_d;
  logic              load_cfg;
  logic              drop;
  logic [BUF_W-1:0]  buf_out;

  // Register the DVP bus once; edges are judged on these copies. vsync resets
  // low so that a frame already in progress at reset release is not mistaken
  // for a fresh frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_r  <= 1'b0;
      vs_rr <= 1'b0;
      hs_r  <= 1'b1;
      hs_rr <= 1'b1;
      d_r   <= '0;
    end else begin
      vs_r  <= dvp_vsync_n;
      vs_rr <= vs_r;
      hs_r  <= dvp_hsync_n;
      hs_rr <= hs_r;
      d_r   <= dvp_data;
    end
  end

  assign vs_assert   =  vs_rr & ~vs_r;
  assign vs_deassert = ~vs_rr &  vs_r;
  assign hs_assert   =  hs_rr & ~hs_r;
  assign hs_deassert = ~hs_rr &  hs_r;

  // Capture the window only when a frame is actually accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_hs <= '0;
      cfg_w  <= '0;
      cfg_vs <= '0;
      cfg_vh <= '0;
    end else if (load_cfg) begin
      cfg_hs <= h_start;
      cfg_w  <= h_width & W_MASK;
      cfg_vs <= v_start;
      cfg_vh <= v_height;
    end
  end

  // Pixel index of the sample currently in d_r: zero on the first active cycle.
  assign cur_pix = hs_deassert ? '0 : pix_q + CNT_ONE;

  // Pixel and line counters; line 0 is the first hsync assert after vsync.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q    <= '0;
      line_idx <= '0;
      line_ok  <= 1'b0;
    end else begin
      if (hs_r) pix_q <= cur_pix;
      if (vs_assert) begin
        line_idx <= '0;
        line_ok  <= 1'b0;
      end else if (hs_assert) begin
        if (line_ok) line_idx <= line_idx + CNT_ONE;
        line_ok <= 1'b1;
      end
    end
  end

  // Window test uses offsets so no wide end-of-window sum is needed.
  assign pix_off  = cur_pix - cfg_hs;
  assign line_off = line_idx - cfg_vs;
  assign in_h     = (cur_pix >= cfg_hs) && (pix_off < cfg_w);
  assign in_v     = line_ok && (line_idx >= cfg_vs) && (line_off < cfg_vh);
  assign cap      = (state_q == FRAME) && !vs_r && hs_r && in_h && in_v;
  assign lane_end = (pix_off[LANE_W-1:0] == LANE_W'(PPW - 1));
  assign px_tuser = (line_off == '0) && (pix_off == CNTW'(PPW - 1));
  assign px_tlast = (pix_off == cfg_w - CNT_ONE);
  assign last_px  = cap && px_tlast && (line_off == cfg_vh - CNT_ONE);
  assign end_ev   = (state_q == FRAME) && (last_px || vs_deassert);

  // Qualified pixel stage; the end-of-frame event travels alongside so the
  // FSM sees it in the same cycle as the final word completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_cap  <= 1'b0;
      q_word <= 1'b0;
      q_user <= 1'b0;
      q_last <= 1'b0;
      q_end  <= 1'b0;
      q_data <= '0;
    end else begin
      q_cap  <= cap;
      q_word <= cap & lane_end;
      q_user <= cap & px_tuser;
      q_last <= cap & px_tlast;
      q_end  <= end_ev;
      q_data <= {{(PIX_W-DW){1'b0}}, d_r};
    end
  end

  // Packing stage: lanes shift in so the first pixel ends up in lane 0. A
  // partial word is simply overwritten by the next line's first three pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      w_data <= '0;
      w_v    <= 1'b0;
      w_user <= 1'b0;
      w_last <= 1'b0;
      w_end  <= 1'b0;
    end else begin
      w_v    <= q_word;
      w_user <= q_user;
      w_last <= q_last;
      w_end  <= q_end;
      if (q_cap)  acc    <= {q_data, acc[ACC_W-1:PIX_W]};
      if (q_word) w_data <= {q_data, acc};
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state and control strobes.
  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    load_cfg   = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (vs_assert && enable) begin
          load_cfg = 1'b1;
          state_d  = FRAME;
        end
      end
      FRAME: begin
        if (w_end) state_d = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Completed-frame counter.
  always_ff @(posedge clk) begin
    if (rst)                   frame_cnt <= '0;
    else if (state_q == DONE)  frame_cnt <= frame_cnt + 16'd1;
  end

  // Sticky overflow, cleared by the start of an enabled frame.
  always_ff @(posedge clk) begin
    if (rst)                       overflow <= 1'b0;
    else if (vs_assert && enable)  overflow <= 1'b0;
    else if (drop)                 overflow <= 1'b1;
  end

  ccd_cap_skidbuf #(
    .W(BUF_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_v),
    .in_data   ({w_last, w_user, w_data}),
    .drop      (drop),
    .out_valid (m_tvalid),
    .out_ready (m_tready),
    .out_data  (buf_out)
  );

  assign m_tdata = buf_out[WORD_W-1:0];
  assign m_tuser = buf_out[TUSER_BIT];
  assign m_tlast = buf_out[TLAST_BIT];

endmodule

// File: tb/tb_ccd_dvp_capture.sv
// Scoreboard bench for ccd_dvp_capture: frame tasks push expected words into a
// queue, a negedge monitor pops and compares every accepted output word.
module tb_ccd_dvp_capture;

  localparam int DW      = 14;
  localparam int CNTW    = 15;
  localparam int LINE_PX = 64;
  localparam int LINES   = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic [CNTW-1:0] h_start, h_width, v_start, v_height;
  logic            dvp_vsync_n, dvp_hsync_n;
  logic [DW-1:0]   dvp_data;
  logic [63:0]     m_tdata;
  logic            m_tvalid, m_tready, m_tuser, m_tlast;
  logic            frame_done, overflow;
  logic [15:0]     frame_cnt;

  ccd_dvp_capture #(.DW(DW), .CNTW(CNTW), .PPW(4)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .h_start(h_start), .h_width(h_width), .v_start(v_start), .v_height(v_height),
    .dvp_vsync_n(dvp_vsync_n), .dvp_hsync_n(dvp_hsync_n), .dvp_data(dvp_data),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tuser(m_tuser), .m_tlast(m_tlast),
    .frame_done(frame_done), .overflow(overflow), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        user;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          rdy_mode = 0;
  int          done_pulses = 0;
  int          done_base = 0;
  int          exp_fc = 0;
  bit          quiet = 1'b0;
  logic [63:0] sof_data = '0;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pix_val(input int l, input int p, input bit tag);
    return tag ? 16'((l << 8) | p) : 16'(p);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Downstream ready pattern: always, one cycle in three, or never.
  initial begin
    int cyc;
    cyc = 0;
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = (cyc % 3 == 0);
        default: m_tready = 1'b0;
      endcase
    end
  end

  // Monitor: stall stability, scoreboard pop on every transfer, pulse count.
  logic        prev_stall = 1'b0;
  logic [65:0] prev_word = '0;
  exp_t        mon_e;
  always @(negedge clk) begin
    if (rst || quiet) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_hold", 66'(m_tvalid), 66'(1));
        check("stall_word_hold", {m_tlast, m_tuser, m_tdata}, prev_word);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h expected none", m_tdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("word_data", 66'(m_tdata), 66'(mon_e.data));
          check("word_tuser", 66'(m_tuser), 66'(mon_e.user));
          check("word_tlast", 66'(m_tlast), 66'(mon_e.last));
        end
        if (m_tuser) sof_data = m_tdata;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_word  = {m_tlast, m_tuser, m_tdata};
      if (frame_done) done_pulses++;
    end
  end

  // Expected words for one frame, from the window arithmetic on 64x8 frames.
  task automatic exp_frame(input int hs, input int hw, input int vs, input int vh,
                           input bit tag, input int max_words);
    int w;
    int n;
    w = hw & ~3;
    n = 0;
    for (int l = vs; l < vs + vh && l < LINES; l++) begin
      for (int j = 0; j < w / 4; j++) begin
        int   p;
        exp_t e;
        p = hs + 4 * j;
        if (p + 3 < LINE_PX && n < max_words) begin
          e.data = '0;
          for (int k = 0; k < 4; k++) e.data[16*k +: 16] = pix_val(l, p + k, tag);
          e.user = (l == vs) && (j == 0);
          e.last = (j == w / 4 - 1);
          exp_q.push_back(e);
          n++;
        end
      end
    end
  endtask

  // Drive one 64 px x 8 line frame; optionally drop enable or pulse rst.
  task automatic run_frame(input int hs, input int hw, input int vs, input int vh,
                           input bit tag, input int en_drop_line, input int rst_line);
    h_start  = CNTW'(hs);
    h_width  = CNTW'(hw);
    v_start  = CNTW'(vs);
    v_height = CNTW'(vh);
    done_base = done_pulses;
    dvp_vsync_n = 1'b1;
    dvp_hsync_n = 1'b1;
    tick(4);
    dvp_vsync_n = 1'b0;
    tick(3);
    for (int l = 0; l < LINES; l++) begin
      if (l == en_drop_line) enable = 1'b0;
      dvp_hsync_n = 1'b0;
      dvp_data    = '0;
      tick(4);
      dvp_hsync_n = 1'b1;
      for (int p = 0; p < LINE_PX; p++) begin
        dvp_data = DW'(pix_val(l, p, tag));
        if (l == rst_line && p == 20) rst = 1'b1;
        if (l == rst_line && p == 21) begin
          @(negedge clk);
          check("rst_tvalid", 66'(m_tvalid), 66'(0));
          check("rst_tdata", 66'(m_tdata), 66'(0));
          check("rst_frame_cnt", 66'(frame_cnt), 66'(0));
        end
        if (l == rst_line && p == 22) begin
          rst   = 1'b0;
          quiet = 1'b0;
          exp_fc = 0;
        end
        tick(1);
      end
    end
    dvp_hsync_n = 1'b0;
    tick(2);
    dvp_vsync_n = 1'b1;
    dvp_hsync_n = 1'b1;
    tick(8);
  endtask

  // Drain with a cycle budget, then check frame-level results.
  task automatic finish_frame(input string name, input int exp_done, input logic exp_ovf);
    int bud;
    bud = 0;
    while (exp_q.size() != 0 && bud < 400) begin
      tick(1);
      bud++;
    end
    tick(4);
    check({name, "_drained"}, 66'(exp_q.size()), 66'(0));
    exp_q.delete();
    check({name, "_frame_done"}, 66'(done_pulses - done_base), 66'(exp_done));
    check({name, "_frame_cnt"}, 66'(frame_cnt), 66'(exp_fc));
    check({name, "_overflow"}, 66'(overflow), 66'(exp_ovf));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    h_start = '0; h_width = '0; v_start = '0; v_height = '0;
    dvp_vsync_n = 1'b1;
    dvp_hsync_n = 1'b1;
    dvp_data = '0;
    tick(3);
    @(negedge clk);
    check("reset_tvalid", 66'(m_tvalid), 66'(0));
    check("reset_tdata", 66'(m_tdata), 66'(0));
    check("reset_tuser", 66'(m_tuser), 66'(0));
    check("reset_tlast", 66'(m_tlast), 66'(0));
    check("reset_frame_done", 66'(frame_done), 66'(0));
    check("reset_overflow", 66'(overflow), 66'(0));
    check("reset_frame_cnt", 66'(frame_cnt), 66'(0));
    tick(1);
    rst = 1'b0;
    tick(2);

    // Basic window: 3 lines x 4 words, data = pixel index.
    exp_frame(8, 16, 2, 3, 1'b0, 99);
    run_frame(8, 16, 2, 3, 1'b0, -1, -1);
    exp_fc = 1;
    finish_frame("basic", 1, 1'b0);
    check("basic_first_word", 66'(sof_data), 66'(64'h000B000A00090008));

    // Backpressure: ready one cycle in three.
    rdy_mode = 1;
    exp_frame(8, 16, 2, 3, 1'b1, 99);
    run_frame(8, 16, 2, 3, 1'b1, -1, -1);
    exp_fc = 2;
    finish_frame("backpressure", 1, 1'b0);
    rdy_mode = 0;

    // Overflow: no ready for the whole frame, only two words survive.
    rdy_mode = 2;
    exp_frame(8, 16, 2, 3, 1'b1, 2);
    run_frame(8, 16, 2, 3, 1'b1, -1, -1);
    rdy_mode = 0;
    exp_fc = 3;
    finish_frame("overflow", 1, 1'b1);

    // Width 18 rounds to 16: four words per line; overflow cleared at vsync.
    exp_frame(20, 18, 1, 2, 1'b1, 99);
    run_frame(20, 18, 1, 2, 1'b1, -1, -1);
    exp_fc = 4;
    finish_frame("width18", 1, 1'b0);

    // Truncated window at line end and frame end: one word per line, no tlast.
    exp_frame(60, 8, 6, 5, 1'b1, 99);
    run_frame(60, 8, 6, 5, 1'b1, -1, -1);
    exp_fc = 5;
    finish_frame("truncated", 1, 1'b0);

    // Enable dropped mid-frame: this frame completes, the next is ignored.
    exp_frame(8, 16, 2, 3, 1'b1, 99);
    run_frame(8, 16, 2, 3, 1'b1, 3, -1);
    exp_fc = 6;
    finish_frame("enable_drop", 1, 1'b0);
    run_frame(8, 16, 2, 3, 1'b1, -1, -1);
    finish_frame("disabled", 0, 1'b0);
    enable = 1'b1;

    // Reset mid-line inside the window; that frame is abandoned.
    quiet = 1'b1;
    run_frame(8, 16, 2, 3, 1'b1, -1, 3);
    finish_frame("reset_abort", 0, 1'b0);

    // First frame after reset starts with tuser on its first word.
    exp_frame(8, 16, 2, 3, 1'b1, 99);
    run_frame(8, 16, 2, 3, 1'b1, -1, -1);
    exp_fc = 1;
    finish_frame("after_reset", 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
